pe_sequencer: RTL
=================

PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter RUN_CYCLES, default 33, the number of PE run cycles per operation.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request an operation; accepted only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT, 01 CUBE, 10 ADD, 11 SUB.
REQ-006 SHALL have ports a, b and c, input, 194 bits each: GF(3^97) operands, 2 bits per trit.
REQ-007 SHALL have port busy, output, 1 bit: high from the start-accept cycle through the capture cycle.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-009 SHALL have port result, output, 194 bits: captured PE output, held until the next capture.
REQ-010 SHALL have port pe_reset, output, 1 bit: reset to the PE.
REQ-011 SHALL have port pe_ctrl, output, 11 bits: control word to the PE.
REQ-012 SHALL have port pe_d0, output, 198 bits: PE operand/opcode word.
REQ-013 SHALL have ports pe_d1 and pe_d2, output, 194 bits each: PE operands.
REQ-014 SHALL have port pe_out, input, 194 bits: PE result.

Function
REQ-015 SHALL implement FSM IDLE -> PRST -> LOAD -> RUN -> DONE -> IDLE.
REQ-016 In IDLE, start=1 SHALL register op, a, b and c, and move the FSM to PRST; a, b and c may change afterwards without effect.
REQ-017 start while not IDLE SHALL be ignored, with no queuing.
REQ-018 PRST SHALL last 1 cycle, with pe_reset=1 and pe_ctrl=0.
REQ-019 LOAD SHALL last 1 cycle, with pe_ctrl=11'b11111_000000.
REQ-020 RUN SHALL last exactly RUN_CYCLES cycles, with pe_ctrl=the run word for the op, driven by a down-counter.
REQ-021 Run words SHALL be: MULT 11'b00000_111111; CUBE 11'b00000_000001; ADD and SUB 11'b00000_010001.
REQ-022 pe_d0 SHALL be driven in PRST, LOAD and RUN as: MULT {4'b0,a}; CUBE {6'b010101,192'b0}; ADD {6'b000101,192'b0}; SUB {6'b001001,192'b0}.
REQ-023 pe_d1 SHALL be b; pe_d2 SHALL be b for MULT and CUBE, and c for ADD and SUB.
REQ-024 On the edge ending the last RUN cycle, result SHALL be loaded with pe_out and the FSM SHALL move to DONE.
REQ-025 DONE SHALL last 1 cycle with done=1 and busy=0; pe_ctrl=0 and start is not accepted until IDLE.
REQ-026 Latency SHALL be: start sampled at edge k gives done high in the cycle after edge k+2+RUN_CYCLES (36 cycles for the default).
REQ-027 In IDLE and DONE, pe_ctrl, pe_d0, pe_d1 and pe_d2 SHALL be 0.

Reset
REQ-028 reset=1 SHALL force IDLE from any state, including mid-RUN, and abort the operation with no done.
REQ-029 Reset values SHALL be: busy=0, done=0, result=0, pe_ctrl=0, pe_d0, pe_d1 and pe_d2=0, counter=0.
REQ-030 pe_reset SHALL be high whenever reset=1, in addition to PRST.
REQ-031 The first start SHALL be accepted in the cycle after reset deasserts.

Structure
REQ-032 A shared package SHALL hold the op encodings, the LOAD control word, the four run control words, the three d0 opcode prefixes, the FSM state type and the RUN_CYCLES default.
REQ-033 The block SHALL NOT instantiate the PE; the bench connects pe_* to one PE instance.
REQ-034 No sub-module is needed; the counter and FSM SHALL be inline.

Verification
REQ-035 MULT: a=15a25886512165251569195908560596a6695612620504191, b=159546442405a181195655549614540592955a15a26984015 -> result=21019120440545215a1462a194a24a6019441081402410969 with done at start+36.
REQ-036 CUBE: b=0894286a45940549565566512aa04a15558406850485454a4 -> result=1049480a48a0855a494855810160a90956659914560616652.
REQ-037 ADD: b=0994544a41588446516618a14691a545542521a4158868428, c=1901269451681914415481656104980811a5a555155546949 -> result=16954a129284915a928a9916a4954141659a96092a11a2165.
REQ-038 SUB: same b and c -> result=209661a62020aa6210125a481599194946404852006625aa2.
REQ-039 start pulsed during RUN -> ignored; exactly one done; result is unchanged from the first op.
REQ-040 reset asserted at RUN cycle 10 -> no done, busy=0 next cycle, result retains its previous value only if the reset is not asserted, otherwise 0; a following MULT completes correctly.

Source files
------------

// File: rtl/pe_sequencer_pkg.sv
// Shared encodings for the PE sequencer: ops, PE control words, d0 opcode prefixes, FSM states.
package pe_sequencer_pkg;

  localparam int RUN_CYCLES_DEF = 33;
  localparam int TW  = 194;
  localparam int D0W = 198;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_CUBE = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [10:0] CTRL_LOAD     = 11'b11111_000000;
  localparam logic [10:0] CTRL_RUN_MULT = 11'b00000_111111;
  localparam logic [10:0] CTRL_RUN_CUBE = 11'b00000_000001;
  localparam logic [10:0] CTRL_RUN_ADD  = 11'b00000_010001;
  localparam logic [10:0] CTRL_RUN_SUB  = 11'b00000_010001;

  localparam logic [5:0] D0_CUBE = 6'b010101;
  localparam logic [5:0] D0_ADD  = 6'b000101;
  localparam logic [5:0] D0_SUB  = 6'b001001;

  function automatic logic [10:0] run_word(input op_e op);
    case (op)
      OP_MULT: run_word = CTRL_RUN_MULT;
      OP_CUBE: run_word = CTRL_RUN_CUBE;
      OP_ADD:  run_word = CTRL_RUN_ADD;
      default: run_word = CTRL_RUN_SUB;
    endcase
  endfunction

  // MULT carries operand a in d0; the other ops carry an opcode prefix instead.
  function automatic logic [D0W-1:0] d0_word(input op_e op, input logic [TW-1:0] a);
    case (op)
      OP_MULT: d0_word = {4'b0000, a};
      OP_CUBE: d0_word = {D0_CUBE, 192'b0};
      OP_ADD:  d0_word = {D0_ADD, 192'b0};
      default: d0_word = {D0_SUB, 192'b0};
    endcase
  endfunction

endpackage

// File: rtl/pe_sequencer.sv
// Sequences one GF(3^97) PE operation: reset PE, load operands, run, capture result.
// Latency: start sampled at edge k -> done high in the cycle after edge k+2+RUN_CYCLES.
// No backpressure: start is only taken in IDLE; requests at any other time are dropped.
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [TW-1:0]   a,
  input  logic [TW-1:0]   b,
  input  logic [TW-1:0]   c,
  output logic            busy,
  output logic            done,
  output logic [TW-1:0]   result,
  output logic            pe_reset,
  output logic [10:0]     pe_ctrl,
  output logic [D0W-1:0]  pe_d0,
  output logic [TW-1:0]   pe_d1,
  output logic [TW-1:0]   pe_d2,
  input  logic [TW-1:0]   pe_out
);

  localparam int CW = $clog2(RUN_CYCLES + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  op_e           op_q;
  logic [TW-1:0] a_q, b_q, c_q;
  logic          last_run;
  logic          drive_ops;

  assign last_run = (state == S_RUN) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        op_q <= op_e'(op);
        a_q  <= a;
        b_q  <= b;
        c_q  <= c;
      end
      // Down-counter reaches zero in the last RUN cycle.
      if (state == S_LOAD)
        cnt <= CW'(RUN_CYCLES - 1);
      else if ((state == S_RUN) && (cnt != '0))
        cnt <= cnt - CW'(1);
      if (last_run)
        result <= pe_out;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pe_reset  = reset;
    pe_ctrl   = '0;
    drive_ops = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_PRST;
      S_PRST: begin
        busy      = 1'b1;
        pe_reset  = 1'b1;
        drive_ops = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        drive_ops = 1'b1;
        pe_ctrl   = CTRL_LOAD;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        drive_ops = 1'b1;
        pe_ctrl   = run_word(op_q);
        if (last_run) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // MULT and CUBE square/cube-feed b on both ports; ADD and SUB need c on the second.
  assign pe_d0 = drive_ops ? d0_word(op_q, a_q) : '0;
  assign pe_d1 = drive_ops ? b_q : '0;
  assign pe_d2 = !drive_ops ? '0 :
                 ((op_q == OP_MULT) || (op_q == OP_CUBE)) ? b_q : c_q;

endmodule
